// File: rtl/dbg_monitor.sv
// rtl/dbg_monitor.sv - CPU clock-enable generator, run/step/halt FSM and debug snapshot (option: DBG_AUTOSCAN_EN)
module dbg_monitor #(
    parameter int DIV_W  = 24,
    parameter int NCH    = 6,
    parameter int W      = 16,
    parameter int SCAN_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [$clog2(DIV_W+1)-1:0] div_shift,
    input  logic                       run,
    input  logic                       step,
    input  logic                       cpu_retired,
    input  logic                       cpu_halted,
    input  logic [$clog2(NCH)-1:0]     ch_sel,
    input  logic [NCH*W-1:0]           dbg_bus,
    output logic                       cpu_ce,
    output logic [W-1:0]               disp_word,
    output logic [$clog2(NCH)-1:0]     disp_ch,
    output logic [1:0]                 state_o
);

    localparam int SW = $clog2(DIV_W+1);
    localparam int CW = $clog2(NCH);
    localparam logic [CW-1:0] NCH_M1 = CW'(NCH-1);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] tick_mask;
    logic [SW-1:0]    shift_c;
    logic             tick;
    logic [CW-1:0]    idx;
    logic [W-1:0]     sel_word;
    logic             ce_d;
    logic             load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Low div_shift bits of the counter all ones marks the end of a period.
    always_comb begin
        shift_c   = (div_shift > SW'(DIV_W)) ? SW'(DIV_W) : div_shift;
        tick_mask = '0;
        for (int i = 0; i < DIV_W; i++) begin
            tick_mask[i] = (SW'(i) < shift_c);
        end
        tick = &(div_cnt | ~tick_mask);
    end

`ifdef DBG_AUTOSCAN_EN
    logic [SCAN_W-1:0] scan_cnt;
    logic [CW-1:0]     scan_idx;
    logic              unused_ch_sel;

    assign unused_ch_sel = ^ch_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (tick && (&div_cnt)) begin
            scan_cnt <= scan_cnt + 1'b1;
            if (&scan_cnt) begin
                scan_idx <= (scan_idx == NCH_M1) ? '0 : scan_idx + 1'b1;
            end
        end
    end

    assign idx = scan_idx;
`else
    assign idx = (ch_sel > NCH_M1) ? '0 : ch_sel;
`endif

    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NCH; k++) begin
            if (idx == CW'(k)) begin
                sel_word = dbg_bus[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_STOP;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_STOP: begin
                if (run)       next_state = ST_RUN;
                else if (step) next_state = ST_STEP;
            end
            ST_RUN: begin
                if (cpu_halted) next_state = ST_HALT;
                else if (!run)  next_state = ST_STOP;
            end
            ST_STEP: begin
                if (cpu_halted)       next_state = ST_HALT;
                else if (cpu_retired) next_state = ST_STOP;
            end
            ST_HALT: begin
                if (!cpu_halted) next_state = ST_STOP;
            end
            default: next_state = ST_STOP;
        endcase
    end

    // A retire or halt seen this cycle suppresses the next pulse so the retiring pulse is the last.
    always_comb begin
        ce_d = 1'b0;
        load = 1'b0;
        case (state)
            ST_RUN:  ce_d = tick && !cpu_halted;
            ST_STEP: ce_d = tick && !cpu_halted && !cpu_retired;
            default: ce_d = 1'b0;
        endcase
        load = cpu_retired || (idx != disp_ch) ||
               ((next_state != state) && ((next_state == ST_STOP) || (next_state == ST_HALT)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_ce    <= 1'b0;
            disp_word <= '0;
            disp_ch   <= '0;
        end else begin
            cpu_ce <= ce_d;
            if (load) begin
                disp_word <= sel_word;
                disp_ch   <= idx;
            end
        end
    end

    assign state_o = state;

endmodule
